dmem_arbiter: RTL and testbench

- Shares one single-port synchronous data memory between two requesters: port A (CPU data port) and port B (host/debug loader).
- Each cycle it grants at most one access, drives the memory port, and routes read data back to the requester that issued the read.
- The owning requester keeps the memory for up to BURST_MAX back-to-back grants. After that the memory is handed to the other requester if it is waiting.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for one single-port synchronous data memory: A (CPU) and B (host/loader).
// Combinational grant with bounded bursts per owner; read data is routed back one cycle after the grant.
module dmem_arbiter #(
  parameter int DW        = 16,
  parameter int AW        = 7,
  parameter int BURST_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_req_i,
  input  logic          a_rw_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wd_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rd_o,
  input  logic          b_req_i,
  input  logic          b_rw_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wd_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rd_o,
  output logic          m_en_o,
  output logic          m_rw_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wd_o,
  input  logic [DW-1:0] m_rd_i
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;   // 0 = A owned last, 1 = B owned last
  logic       rv_a_q, rv_b_q;
  logic       gnt_a, gnt_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      rv_a_q  <= 1'b0;
      rv_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rv_a_q  <= gnt_a & a_rw_i;
      rv_b_q  <= gnt_b & b_rw_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (gnt_a) begin
      if (state_q == OWN_A) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        state_d = OWN_A;
        cnt_d   = 4'd1;
        last_d  = 1'b0;
      end
    end else if (gnt_b) begin
      if (state_q == OWN_B) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        state_d = OWN_B;
        cnt_d   = 4'd1;
        last_d  = 1'b1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // The owner keeps the port until its burst is spent and the other side is waiting.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        OWN_A: begin
          if (a_req_i && (cnt_q < BURST_LIM || !b_req_i)) gnt_a = 1'b1;
          else                                            gnt_b = b_req_i;
        end
        OWN_B: begin
          if (b_req_i && (cnt_q < BURST_LIM || !a_req_i)) gnt_b = 1'b1;
          else                                            gnt_a = a_req_i;
        end
        default: begin
          if (a_req_i && b_req_i) begin
            gnt_a = last_q;
            gnt_b = !last_q;
          end else begin
            gnt_a = a_req_i;
            gnt_b = b_req_i;
          end
        end
      endcase
    end
  end

  always_comb begin
    a_gnt_o  = gnt_a;
    b_gnt_o  = gnt_b;
    m_en_o   = gnt_a | gnt_b;
    m_rw_o   = 1'b1;
    m_addr_o = '0;
    m_wd_o   = '0;
    if (gnt_a) begin
      m_rw_o   = a_rw_i;
      m_addr_o = a_addr_i;
      m_wd_o   = a_wd_i;
    end else if (gnt_b) begin
      m_rw_o   = b_rw_i;
      m_addr_o = b_addr_i;
      m_wd_o   = b_wd_i;
    end
  end

  // A read in flight when reset arrives is dropped immediately.
  assign a_rvalid_o = rv_a_q & ~rst_i;
  assign b_rvalid_o = rv_b_q & ~rst_i;
  assign a_rd_o     = a_rvalid_o ? m_rd_i : '0;
  assign b_rd_o     = b_rvalid_o ? m_rd_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: spec-level model checked every cycle plus directed literal checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_rw, b_req, b_rw;
  logic [6:0]  a_addr, b_addr;
  logic [15:0] a_wd, b_wd;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rd, b_rd;
  logic        m_en, m_rw;
  logic [6:0]  m_addr;
  logic [15:0] m_wd, m_rd;

  logic        p_a_req, p_b_req;
  logic        p_a_gnt, p_a_rvalid, p_b_gnt, p_b_rvalid;
  logic [15:0] p_a_rd, p_b_rd;
  logic        p_m_en, p_m_rw;
  logic [6:0]  p_m_addr;
  logic [15:0] p_m_wd;
  logic [15:0] p_m_rd = 16'h0;
  logic        p_rw = 1'b1;
  logic [6:0]  p_addr = 7'd9;
  logic [15:0] p_wd = 16'h0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(16), .AW(7), .BURST_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_rw_i(a_rw), .a_addr_i(a_addr), .a_wd_i(a_wd),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rd_o(a_rd),
    .b_req_i(b_req), .b_rw_i(b_rw), .b_addr_i(b_addr), .b_wd_i(b_wd),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rd_o(b_rd),
    .m_en_o(m_en), .m_rw_o(m_rw), .m_addr_o(m_addr), .m_wd_o(m_wd), .m_rd_i(m_rd)
  );

  dmem_arbiter #(.DW(16), .AW(7), .BURST_MAX(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(p_a_req), .a_rw_i(p_rw), .a_addr_i(p_addr), .a_wd_i(p_wd),
    .a_gnt_o(p_a_gnt), .a_rvalid_o(p_a_rvalid), .a_rd_o(p_a_rd),
    .b_req_i(p_b_req), .b_rw_i(p_rw), .b_addr_i(p_addr), .b_wd_i(p_wd),
    .b_gnt_o(p_b_gnt), .b_rvalid_o(p_b_rvalid), .b_rd_o(p_b_rd),
    .m_en_o(p_m_en), .m_rw_o(p_m_rw), .m_addr_o(p_m_addr), .m_wd_o(p_m_wd), .m_rd_i(p_m_rd)
  );

  // Memory attached to the main DUT.
  logic [15:0] bmem [128];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_rw) m_rd <= bmem[m_addr];
      else      bmem[m_addr] <= m_wd;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=A 2=B; run = consecutive grants to owner; last owner for ties.
  int          mo_owner, mo_run, mo_last, winner;
  bit          mo_rva, mo_rvb;
  logic [15:0] mo_rda, mo_rdb;
  logic [15:0] mo_mem [128];
  bit          chk_en = 1'b0;
  bit          hist_on = 1'b0;
  int          hist[$];

  always @(negedge clk) begin
    winner = 0;
    if (!rst) begin
      if (a_req && b_req) begin
        if (mo_owner == 0)      winner = (mo_last == 2) ? 1 : 2;
        else if (mo_run < 4)    winner = mo_owner;
        else                    winner = 3 - mo_owner;
      end else if (a_req) winner = 1;
      else if (b_req)     winner = 2;
    end
    if (chk_en) begin
      chk("a_gnt", a_gnt, winner == 1);
      chk("b_gnt", b_gnt, winner == 2);
      chk("one_gnt", a_gnt & b_gnt, 0);
      chk("m_en", m_en, winner != 0);
      chk("m_rw", m_rw, winner == 1 ? a_rw : winner == 2 ? b_rw : 1'b1);
      chk("m_addr", m_addr, winner == 1 ? a_addr : winner == 2 ? b_addr : 7'd0);
      chk("m_wd", m_wd, winner == 1 ? a_wd : winner == 2 ? b_wd : 16'd0);
      chk("a_rvalid", a_rvalid, mo_rva && !rst);
      chk("b_rvalid", b_rvalid, mo_rvb && !rst);
      chk("a_rd", a_rd, (mo_rva && !rst) ? mo_rda : 16'd0);
      chk("b_rd", b_rd, (mo_rvb && !rst) ? mo_rdb : 16'd0);
    end
    if (hist_on) hist.push_back(a_gnt ? 1 : b_gnt ? 2 : 0);
    if (rst) begin
      mo_owner = 0; mo_run = 0; mo_last = 2; mo_rva = 0; mo_rvb = 0;
    end else begin
      mo_rva = (winner == 1) && a_rw;
      mo_rvb = (winner == 2) && b_rw;
      if (winner == 1) begin
        mo_rda = mo_mem[a_addr];
        if (!a_rw) mo_mem[a_addr] = a_wd;
      end
      if (winner == 2) begin
        mo_rdb = mo_mem[b_addr];
        if (!b_rw) mo_mem[b_addr] = b_wd;
      end
      if (winner == 0) begin
        mo_owner = 0; mo_run = 0;
      end else if (winner == mo_owner) begin
        mo_run = (mo_run >= 15) ? 15 : mo_run + 1;
      end else begin
        mo_owner = winner; mo_run = 1; mo_last = winner;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hist(input string name, input int exp[]);
    chk({name, "_len"}, hist.size(), exp.size());
    for (int i = 0; i < exp.size() && i < hist.size(); i++)
      chk(name, hist[i], exp[i]);
    hist.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t required below 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p_hist[$];
    bit got;
    int bcount;
    for (int i = 0; i < 128; i++) begin
      bmem[i]   = 16'(i - 1);
      mo_mem[i] = 16'(i - 1);
    end
    rst = 1'b1;
    a_req = 0; a_rw = 1; a_addr = 0; a_wd = 0;
    b_req = 0; b_rw = 1; b_addr = 0; b_wd = 0;
    p_a_req = 0; p_b_req = 0;
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_rw", m_rw, 1);
    cyc(); cyc();
    rst = 1'b0;

    // Single uncontended read of address 5.
    a_req = 1; a_rw = 1; a_addr = 7'd5;
    @(negedge clk);
    chk("t1_gnt", a_gnt, 1);
    chk("t1_addr", m_addr, 7'd5);
    chk("t1_rw", m_rw, 1);
    cyc();
    a_req = 0;
    @(negedge clk);
    chk("t1_rvalid", a_rvalid, 1);
    chk("t1_rd", a_rd, 16'h0004);
    chk("t1_b_rvalid", b_rvalid, 0);
    cyc();

    // Continuous contention after reset: bursts of four.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_req = 1; a_addr = 7'd1; b_req = 1; b_rw = 1; b_addr = 7'd2;
    hist_on = 1'b1;
    repeat (10) cyc();
    hist_on = 1'b0;
    chk_hist("t2_pattern", '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1});
    a_req = 0; b_req = 0;
    cyc();

    // A write to address 0 interleaved with B reading address 0.
    a_req = 1; a_rw = 0; a_addr = 7'd0; a_wd = 16'h0004;
    b_req = 1; b_rw = 1; b_addr = 7'd0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_gnt) got = 1;
      else cyc();
    end
    chk("t3_a_granted", got, 1);
    cyc();
    a_req = 0; a_rw = 1;
    @(negedge clk);
    chk("t3_no_wr_rvalid", a_rvalid, 0);
    chk("t3_b_gnt", b_gnt, 1);
    cyc();
    @(negedge clk);
    chk("t3_b_rvalid", b_rvalid, 1);
    chk("t3_b_rd", b_rd, 16'h0004);
    b_req = 0;
    cyc();

    // A drops after two grants while B waits; then B runs alone.
    a_req = 1; a_rw = 1; a_addr = 7'd4; b_req = 1; b_addr = 7'd3;
    @(negedge clk);
    chk("t4_a1", a_gnt, 1);
    cyc();
    @(negedge clk);
    chk("t4_a2", a_gnt, 1);
    cyc();
    a_req = 0;
    @(negedge clk);
    chk("t4_b_next", b_gnt, 1);
    bcount = 0;
    repeat (10) begin
      cyc();
      @(negedge clk);
      if (b_gnt) bcount++;
    end
    chk("t4_b_alone", bcount, 10);

    // Reset one cycle after a granted B read.
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_b_rvalid", b_rvalid, 0);
    chk("t5_b_gnt", b_gnt, 0);
    chk("t5_m_en", m_en, 0);
    cyc();
    rst = 1'b0;
    a_req = 1;
    @(negedge clk);
    chk("t5_tie_a", a_gnt, 1);
    cyc();
    a_req = 0; b_req = 0;
    cyc();

    // BURST_MAX=1 instance: strict alternation.
    p_a_req = 1; p_b_req = 1;
    repeat (6) begin
      @(negedge clk);
      p_hist.push_back(p_a_gnt ? 1 : p_b_gnt ? 2 : 0);
      chk("t6_one_gnt", p_a_gnt & p_b_gnt, 0);
      cyc();
    end
    p_a_req = 0; p_b_req = 0;
    hist = p_hist;
    chk_hist("t6_alternate", '{1, 2, 1, 2, 1, 2});
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
